gate_bist_ctrl: RTL and testbench

- Built-in self-test sequencer for the 10-input/10-output combinational gate-model netlists in the simulator gate library.
- Drives the netlist input vector from an LFSR pattern generator and waits a programmable settle time per pattern.
- Compacts each output vector into a MISR and compares the final signature against a golden value.
- Sits between the lab bench/host and one gate model; the gate model itself stays purely combinational.

---
 rtl/gate_bist_pkg.sv | 22 ++
 rtl/gate_bist_shreg.sv | 32 +++
 rtl/gate_bist_ctrl.sv | 146 ++++++++++++++
 tb/tb_gate_bist_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-model BIST sequencer.
// Holds the FSM state encoding, default LFSR/MISR constants and the feedback helper.
package gate_bist_pkg;

    localparam int          DEFAULT_WIDTH = 10;
    localparam logic [9:0]  DEFAULT_TAPS  = 10'h240;
    localparam logic [9:0]  DEFAULT_SEED  = 10'h001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } bist_state_e;

    // Vectors are zero-extended to 32 bits so one helper serves any width up to 32.
    function automatic logic feedback(input logic [31:0] vec, input logic [31:0] taps);
        return ^(vec & taps);
    endfunction

endpackage

// File: rtl/gate_bist_shreg.sv
// Loadable shift register with XOR feedback; serves as the pattern LFSR
// (xor_in tied to zero) and as the response-compacting MISR.
module bist_shreg
    import gate_bist_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] xor_in_i,
    output logic [WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] value_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= '0;
        end else if (load_i) begin
            value_q <= load_val_i;
        end else if (step_i) begin
            value_q <= {value_q[WIDTH-2:0], feedback(32'(value_q), 32'(TAPS))} ^ xor_in_i;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for a combinational gate model: LFSR patterns in, settle wait,
// MISR compaction of the responses, final signature compare against a golden value.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int               WIDTH         = DEFAULT_WIDTH,
    parameter int               NUM_PATTERNS  = 256,
    parameter int               SETTLE_CYCLES = 4,
    parameter logic [WIDTH-1:0] SEED          = WIDTH'(DEFAULT_SEED),
    parameter logic [WIDTH-1:0] TAPS          = WIDTH'(DEFAULT_TAPS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] expected_sig_i,
    output logic [WIDTH-1:0] dut_in_o,
    input  logic [WIDTH-1:0] dut_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [WIDTH-1:0] signature_o,
    output logic [15:0]      pattern_cnt_o
);

    // An all-zero seed would lock the LFSR, and a zero settle time still needs one cycle.
    localparam logic [WIDTH-1:0] SEED_EFF   = (SEED == '0) ? WIDTH'(1) : SEED;
    localparam int               SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int               CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(SETTLE_EFF - 1);
    localparam logic [15:0]      LAST_PAT   = 16'(NUM_PATTERNS);

    bist_state_e      state_q;
    logic [CNT_W-1:0] waitCnt_q;
    logic [15:0]      patternCnt_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    logic [15:0]      patternCnt_d;
    logic             seedLoad;
    logic             captureStep;
    logic [WIDTH-1:0] lfsrValue;
    logic [WIDTH-1:0] misrValue;

    always_comb begin
        patternCnt_d = patternCnt_q + 16'd1;
        seedLoad     = (state_q == ST_SEED) && !abort_i;
        captureStep  = (state_q == ST_CAPTURE) && !abort_i;
    end

    bist_shreg #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (seedLoad),
        .load_val_i (SEED_EFF),
        .step_i     (captureStep),
        .xor_in_i   ('0),
        .value_o    (lfsrValue)
    );

    bist_shreg #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_misr (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (seedLoad),
        .load_val_i ('0),
        .step_i     (captureStep),
        .xor_in_i   (dut_out_i),
        .value_o    (misrValue)
    );

    // Abort from any active state beats every other transition, including start in IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            waitCnt_q    <= '0;
            patternCnt_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i && state_q != ST_IDLE) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                pass_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i && !abort_i) begin
                            state_q <= ST_SEED;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_SEED: begin
                        patternCnt_q <= '0;
                        pass_q       <= 1'b0;
                        waitCnt_q    <= WAIT_LOAD;
                        state_q      <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (waitCnt_q == '0) begin
                            state_q <= ST_CAPTURE;
                        end else begin
                            waitCnt_q <= waitCnt_q - 1'b1;
                        end
                    end
                    ST_CAPTURE: begin
                        if (patternCnt_d >= LAST_PAT) begin
                            patternCnt_q <= LAST_PAT;
                            state_q      <= ST_DONE;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                        end else begin
                            patternCnt_q <= patternCnt_d;
                            waitCnt_q    <= WAIT_LOAD;
                            state_q      <= ST_SETTLE;
                        end
                    end
                    ST_DONE: begin
                        pass_q  <= (misrValue == expected_sig_i);
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dut_in_o      = lfsrValue;
    assign signature_o   = misrValue;
    assign pattern_cnt_o = patternCnt_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign pass_o        = pass_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: a small instance (4 patterns, settle 2) driven from a vector
// table and hand sequences, plus a default-parameter instance against a gate model.
module tb_gate_bist_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        startA  = 1'b0;
    logic        abortA  = 1'b0;
    logic [9:0]  expSigA = '0;
    logic [9:0]  dutInA;
    logic [9:0]  dutOutA;
    logic        busyA, doneA, passA;
    logic [9:0]  sigA;
    logic [15:0] cntA;
    logic        loopA   = 1'b1;
    logic [9:0]  constA  = '0;

    logic        startB  = 1'b0;
    logic        abortB  = 1'b0;
    logic [9:0]  expSigB = '0;
    logic [9:0]  dutInB;
    logic [9:0]  dutOutB;
    logic        busyB, doneB, passB;
    logic [9:0]  sigB;
    logic [15:0] cntB;
    logic        flipB   = 1'b0;

    gate_bist_ctrl #(
        .WIDTH         (10),
        .NUM_PATTERNS  (4),
        .SETTLE_CYCLES (2),
        .SEED          (10'h001),
        .TAPS          (10'h240)
    ) dutA (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (startA),
        .abort_i        (abortA),
        .expected_sig_i (expSigA),
        .dut_in_o       (dutInA),
        .dut_out_i      (dutOutA),
        .busy_o         (busyA),
        .done_o         (doneA),
        .pass_o         (passA),
        .signature_o    (sigA),
        .pattern_cnt_o  (cntA)
    );

    gate_bist_ctrl dutB (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (startB),
        .abort_i        (abortB),
        .expected_sig_i (expSigB),
        .dut_in_o       (dutInB),
        .dut_out_i      (dutOutB),
        .busy_o         (busyB),
        .done_o         (doneB),
        .pass_o         (passB),
        .signature_o    (sigB),
        .pattern_cnt_o  (cntB)
    );

    // Stand-in combinational gate model for the default-parameter run.
    function automatic logic [9:0] netFn(input logic [9:0] x);
        return {x[4:0] ^ x[9:5], ~x[9:5] | x[4:0]};
    endfunction

    function automatic logic [9:0] stepFn(input logic [9:0] v);
        return {v[8:0], v[9] ^ v[6]};
    endfunction

    always_comb dutOutA = loopA ? dutInA : constA;
    always_comb dutOutB = netFn(dutInB) ^ ((flipB && cntB == 16'd100) ? 10'h010 : 10'h000);

    typedef struct {
        string      name;
        logic       loop;
        logic [9:0] constOut;
        logic [9:0] expSig;
        logic [9:0] wantSig;
        logic       wantPass;
    } vec_t;

    vec_t vecs[3];

    int checks = 0;
    int errors = 0;

    int         doneCycle;
    int         doneCount;
    logic       passAfter;
    logic       busyMid;
    logic       snapBusy;
    logic       snapPass;
    logic [15:0] snapCnt;
    logic [9:0] seqA[4];
    logic [9:0] golden;
    logic [9:0] wantSeq[4];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One run of instance A; n counts rising edges after the start-sampling edge.
    task automatic applyStimulus(input logic [9:0] expSig, input int startAt, input int abortAt);
        expSigA   = expSig;
        doneCycle = -1;
        doneCount = 0;
        passAfter = 1'b0;
        busyMid   = 1'b0;
        snapBusy  = 1'b1;
        snapPass  = 1'b1;
        snapCnt   = '1;
        @(negedge clk);
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n >= 2 && n <= 11 && ((n - 2) % 3) == 0) seqA[(n - 2) / 3] = dutInA;
            if (n == 5) busyMid = busyA;
            if (doneA) begin
                if (doneCycle < 0) doneCycle = n;
                doneCount++;
            end
            if (doneCycle >= 0 && n == doneCycle + 1) passAfter = passA;
            if (n == abortAt + 1) begin
                snapBusy = busyA;
                snapPass = passA;
                snapCnt  = cntA;
            end
            startA = (n == startAt);
            abortA = (n == abortAt);
        end
        startA = 1'b0;
        abortA = 1'b0;
    endtask

    task automatic runB(input logic doFlip);
        flipB     = doFlip;
        expSigB   = golden;
        doneCycle = -1;
        doneCount = 0;
        passAfter = 1'b0;
        @(negedge clk);
        startB = 1'b1;
        @(negedge clk);
        startB = 1'b0;
        for (int n = 1; n <= 1400; n++) begin
            @(negedge clk);
            if (doneB) begin
                if (doneCycle < 0) doneCycle = n;
                doneCount++;
            end
            if (doneCycle >= 0 && n == doneCycle + 1) passAfter = passB;
        end
        flipB = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"loopback",      1'b1, 10'h000, 10'h000, 10'h000, 1'b1};
        vecs[1] = '{"const3ff_bad",  1'b0, 10'h3FF, 10'h000, 10'h005, 1'b0};
        vecs[2] = '{"const3ff_good", 1'b0, 10'h3FF, 10'h005, 10'h005, 1'b1};
        wantSeq[0] = 10'h001;
        wantSeq[1] = 10'h002;
        wantSeq[2] = 10'h004;
        wantSeq[3] = 10'h008;

        begin
            logic [9:0] l;
            logic [9:0] m;
            l = 10'h001;
            m = 10'h000;
            for (int i = 0; i < 256; i++) begin
                m = stepFn(m) ^ netFn(l);
                l = stepFn(l);
            end
            golden = m;
        end

        repeat (3) @(negedge clk);
        checkOutput("reset dut_in", 32'(dutInA), 32'h0);
        checkOutput("reset signature", 32'(sigA), 32'h0);
        checkOutput("reset pattern_cnt", 32'(cntA), 32'h0);
        checkOutput("reset busy", 32'(busyA), 32'h0);
        checkOutput("reset done", 32'(doneA), 32'h0);
        checkOutput("reset pass", 32'(passA), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            loopA  = vecs[i].loop;
            constA = vecs[i].constOut;
            applyStimulus(vecs[i].expSig, -1, -1);
            if (vecs[i].loop) begin
                for (int k = 0; k < 4; k++)
                    checkOutput($sformatf("%s dut_in[%0d]", vecs[i].name, k), 32'(seqA[k]), 32'(wantSeq[k]));
            end
            checkOutput($sformatf("%s done cycle", vecs[i].name), 32'(doneCycle), 32'd13);
            checkOutput($sformatf("%s done count", vecs[i].name), 32'(doneCount), 32'd1);
            checkOutput($sformatf("%s busy mid", vecs[i].name), 32'(busyMid), 32'd1);
            checkOutput($sformatf("%s busy end", vecs[i].name), 32'(busyA), 32'd0);
            checkOutput($sformatf("%s signature", vecs[i].name), 32'(sigA), 32'(vecs[i].wantSig));
            checkOutput($sformatf("%s pattern_cnt", vecs[i].name), 32'(cntA), 32'd4);
            checkOutput($sformatf("%s pass", vecs[i].name), 32'(passAfter), 32'(vecs[i].wantPass));
        end

        loopA = 1'b1;
        applyStimulus(10'h000, 4, -1);
        checkOutput("restart done count", 32'(doneCount), 32'd1);
        checkOutput("restart done cycle", 32'(doneCycle), 32'd13);
        checkOutput("restart pattern_cnt", 32'(cntA), 32'd4);

        loopA  = 1'b0;
        constA = 10'h3FF;
        applyStimulus(10'h001, -1, 9);
        checkOutput("abort done count", 32'(doneCount), 32'd0);
        checkOutput("abort busy", 32'(snapBusy), 32'd0);
        checkOutput("abort pass", 32'(snapPass), 32'd0);
        checkOutput("abort pattern_cnt", 32'(snapCnt), 32'd2);
        checkOutput("abort signature", 32'(sigA), 32'h001);
        checkOutput("abort pattern_cnt held", 32'(cntA), 32'd2);

        loopA   = 1'b1;
        expSigA = 10'h000;
        @(negedge clk);
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("pre-reset busy", 32'(busyA), 32'd1);
        checkOutput("pre-reset pattern_cnt", 32'(cntA), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset dut_in", 32'(dutInA), 32'h0);
        checkOutput("async reset signature", 32'(sigA), 32'h0);
        checkOutput("async reset pattern_cnt", 32'(cntA), 32'h0);
        checkOutput("async reset busy", 32'(busyA), 32'h0);
        checkOutput("async reset done", 32'(doneA), 32'h0);
        checkOutput("async reset pass", 32'(passA), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(10'h000, -1, -1);
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("post-reset dut_in[%0d]", k), 32'(seqA[k]), 32'(wantSeq[k]));
        checkOutput("post-reset done cycle", 32'(doneCycle), 32'd13);
        checkOutput("post-reset signature", 32'(sigA), 32'h000);
        checkOutput("post-reset pass", 32'(passAfter), 32'd1);

        runB(1'b0);
        checkOutput("gate done cycle", 32'(doneCycle), 32'd1281);
        checkOutput("gate done count", 32'(doneCount), 32'd1);
        checkOutput("gate signature", 32'(sigB), 32'(golden));
        checkOutput("gate pattern_cnt", 32'(cntB), 32'd256);
        checkOutput("gate pass", 32'(passAfter), 32'd1);

        runB(1'b1);
        checkOutput("gate flip done cycle", 32'(doneCycle), 32'd1281);
        checkOutput("gate flip signature differs", 32'(sigB != golden), 32'd1);
        checkOutput("gate flip pass", 32'(passAfter), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
